// File: rtl/ram_pkg.sv
// Shared constants and geometry helper for the ram block.
package ram_pkg;

  localparam int DEFAULT_BIT_SIZE  = 1024;
  localparam int DEFAULT_BIT_DEPTH = 8;

  typedef struct packed {
    logic [31:0] depth;
    logic [31:0] addr_w;
  } ram_geom_t;

  // Word count and address width; a one-word memory still needs a 1-bit address.
  function automatic ram_geom_t ram_geom(input int bit_size, input int bit_depth);
    ram_geom_t g;
    int        d;
    d        = bit_size / bit_depth;
    g.depth  = d;
    g.addr_w = (d > 1) ? $clog2(d) : 1;
    return g;
  endfunction

endpackage

// File: rtl/ram_parity.sv
// Combinational even-parity generator/checker for one RAM word.
module ram_parity
  import ram_pkg::*;
#(
  parameter int BIT_DEPTH = DEFAULT_BIT_DEPTH
) (
  input  logic [BIT_DEPTH-1:0] data,
  output logic                 parity
);

  assign parity = ^data;

endmodule

// File: rtl/ram.sv
// ram: single-port synchronous RAM, flop-based so rst_n can clear it; read-before-write.
// Optional macro RAM_PARITY_EN adds a stored even-parity bit per word and a registered parity_err.
module ram
  import ram_pkg::*;
#(
  parameter int  BIT_SIZE  = DEFAULT_BIT_SIZE,
  parameter int  BIT_DEPTH = DEFAULT_BIT_DEPTH,
  localparam ram_geom_t GEOM = ram_geom(BIT_SIZE, BIT_DEPTH),
  localparam int DEPTH  = int'(GEOM.depth),
  localparam int ADDR_W = int'(GEOM.addr_w)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 wen,
  input  logic [BIT_DEPTH-1:0] data_in,
  output logic [BIT_DEPTH-1:0] data_out
`ifdef RAM_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

`ifdef RAM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int WORD_W = BIT_DEPTH + PAR_W;

  if (BIT_SIZE % BIT_DEPTH != 0) begin : g_bad_size
    $error("ram: BIT_SIZE must be a multiple of BIT_DEPTH");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("ram: DEPTH must be at least 2");
  end

  logic [WORD_W-1:0]    mem_reg [DEPTH];
  logic [WORD_W-1:0]    wr_word;
  logic [WORD_W-1:0]    rd_word;
  logic                 addr_in_range;
  logic [BIT_DEPTH-1:0] data_out_reg;

  // Only reachable when DEPTH is not a power of two.
  assign addr_in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));

  always_comb begin
    rd_word = '0;
    if (addr_in_range) begin
      rd_word = mem_reg[addr];
    end
  end

`ifdef RAM_PARITY_EN
  logic wr_par;
  logic rd_par;
  logic parity_err_reg;

  ram_parity #(.BIT_DEPTH(BIT_DEPTH)) u_par_gen (
    .data   (data_in),
    .parity (wr_par)
  );

  ram_parity #(.BIT_DEPTH(BIT_DEPTH)) u_par_chk (
    .data   (rd_word[BIT_DEPTH-1:0]),
    .parity (rd_par)
  );

  assign wr_word = {wr_par, data_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_reg <= 1'b0;
    end else begin
      parity_err_reg <= rd_word[BIT_DEPTH] ^ rd_par;
    end
  end

  assign parity_err = parity_err_reg;
`else
  assign wr_word = data_in;
`endif

  // Read samples the pre-write contents, giving read-before-write on a shared address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      data_out_reg <= '0;
    end else begin
      if (wen && addr_in_range) begin
        mem_reg[addr] <= wr_word;
      end
      data_out_reg <= rd_word[BIT_DEPTH-1:0];
    end
  end

  assign data_out = data_out_reg;

endmodule

// File: tb/tb_ram.sv
// Self-checking bench for ram: random traffic against an array model plus pinned literal checks.
module tb_ram;

  localparam int DEPTH = 128;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic [6:0] addr     = '0;
  logic       wen      = 1'b0;
  logic [7:0] data_in  = '0;
  logic [7:0] data_out;
`ifdef RAM_PARITY_EN
  logic             parity_err;
  logic [DEPTH-1:0] bad_par = '0;
`endif

  always #5 clk = ~clk;

  ram dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .wen      (wen),
    .data_in  (data_in),
    .data_out (data_out)
`ifdef RAM_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  typedef struct {
    logic [7:0] d;
    logic       p;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] model [DEPTH];
  int         total = 0;
  int         bad   = 0;
  int         txn   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %02h required %02h", name, act, req);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
`ifdef RAM_PARITY_EN
    bad_par = '0;
`endif
  endtask

  // One clock of traffic; returns 1 time unit after the edge that sampled it.
  task automatic drive(input logic [6:0] a, input logic w, input logic [7:0] d);
    exp_t e;
    addr    = a;
    wen     = w;
    data_in = d;
    @(posedge clk);
    if (rst_n) begin
      e.d = model[a];
`ifdef RAM_PARITY_EN
      e.p = bad_par[a];
      if (w) bad_par[a] = 1'b0;
`else
      e.p = 1'b0;
`endif
      exp_q.push_back(e);
      if (w) model[a] = d;
    end
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      txn++;
      $display("txn %0d: addr=%02h data_out=%02h expect=%02h", txn, addr, data_out, e.d);
      check("rd_data", data_out, e.d);
`ifdef RAM_PARITY_EN
      check("parity_err", {7'd0, parity_err}, {7'd0, e.p});
`endif
    end
  end

  initial begin
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_out", data_out, 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) drive(7'(i), 1'b0, 8'($urandom));
    for (int i = 0; i < DEPTH; i++) drive(7'(i), 1'b1, 8'($urandom));
    for (int i = 0; i < DEPTH; i++) drive(7'(i), 1'b0, 8'($urandom));

    // Read-during-write returns the old word.
    drive(7'd5, 1'b1, 8'h3C);
    drive(7'd5, 1'b1, 8'hA5);
    check("rdw_old", data_out, 8'h3C);
    drive(7'd5, 1'b0, 8'h00);
    check("rdw_new", data_out, 8'hA5);

    drive(7'd127, 1'b1, 8'hFF);
    drive(7'd0, 1'b1, 8'h01);
    drive(7'd0, 1'b0, 8'h00);
    check("iso_addr0", data_out, 8'h01);
    drive(7'd127, 1'b0, 8'h00);
    check("iso_addr127", data_out, 8'hFF);
    for (int i = 0; i < DEPTH; i++) drive(7'(i), 1'b0, 8'h00);

    repeat (300) drive(7'($urandom_range(DEPTH - 1)), 1'($urandom), 8'($urandom));

`ifdef RAM_PARITY_EN
    drive(7'd9, 1'b1, 8'h07);
    drive(7'd9, 1'b0, 8'h00);
    check("par_good_data", data_out, 8'h07);
    check("par_good_err", {7'd0, parity_err}, 8'h00);
    force dut.mem_reg[9] = 9'h106;
    model[9]   = 8'h06;
    bad_par[9] = 1'b1;
    drive(7'd9, 1'b0, 8'h00);
    check("par_flip_data", data_out, 8'h06);
    check("par_flip_err", {7'd0, parity_err}, 8'h01);
    release dut.mem_reg[9];
    drive(7'd9, 1'b1, 8'h07);
`endif

    // Asynchronous reset in the middle of a write burst.
    drive(7'd3, 1'b1, 8'hC3);
    drive(7'd3, 1'b1, 8'h5A);
    check("pre_reset_read", data_out, 8'hC3);
    drive(7'd10, 1'b1, 8'h77);
    exp_q.delete();
    clear_model();
    rst_n = 1'b0;
    #1;
    check("async_reset_data_out", data_out, 8'h00);
`ifdef RAM_PARITY_EN
    check("async_reset_parity", {7'd0, parity_err}, 8'h00);
`endif
    drive(7'd10, 1'b1, 8'h99);
    drive(7'd11, 1'b1, 8'h66);
    rst_n = 1'b1;
    drive(7'd10, 1'b0, 8'h00);
    check("post_reset_addr10", data_out, 8'h00);
    for (int i = 0; i < DEPTH; i++) drive(7'(i), 1'b0, 8'h00);

    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
